// File: rtl/tmp_meas_sched.sv
// tmp_meas_sched: sequences front-end reset and settling, then decimates comparator
// decisions over an oversampling window into a result returned via valid/ready.
module tmp_meas_sched #(
    parameter int OSR_W       = 10,
    parameter int RST_CYC     = 4,
    parameter int SETTLE_SMP  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             cont,
    input  logic [OSR_W-1:0] osr,
    input  logic             abort,
    input  logic             cyc_done,
    input  logic             cmp,
    output logic             dig_rst,
    output logic             busy,
    output logic [OSR_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             err_timeout,
    output logic             overrun
);
    localparam int RC_W = $clog2(RST_CYC + 1);
    localparam int SC_W = $clog2(SETTLE_SMP + 2);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, RESET_DIG, SETTLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [RC_W-1:0]  rst_cnt;
    logic [SC_W-1:0]  set_cnt;
    logic [WD_W-1:0]  wd;
    logic [OSR_W-1:0] osr_l;
    logic [OSR_W-1:0] smp;
    logic [OSR_W-1:0] acc;
    logic             cont_l;
    logic             wd_exp;
    logic             smp_last;

    assign busy     = state != IDLE;
    assign wd_exp   = !cyc_done && wd == WD_W'(TIMEOUT_CYC - 1);
    assign smp_last = smp + OSR_W'(1) == osr_l;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            dig_rst      <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
            err_timeout  <= 1'b0;
            overrun      <= 1'b0;
            rst_cnt      <= '0;
            set_cnt      <= '0;
            wd           <= '0;
            osr_l        <= '0;
            smp          <= '0;
            acc          <= '0;
            cont_l       <= 1'b0;
        end else if (abort) begin
            state        <= IDLE;
            dig_rst      <= 1'b1;
            result_valid <= 1'b0;
            rst_cnt      <= '0;
            set_cnt      <= '0;
            wd           <= '0;
            smp          <= '0;
            acc          <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state       <= RESET_DIG;
                    osr_l       <= osr == '0 ? OSR_W'(1) : osr;
                    cont_l      <= cont;
                    err_timeout <= 1'b0;
                    overrun     <= 1'b0;
                    rst_cnt     <= '0;
                end
                RESET_DIG: if (rst_cnt == RC_W'(RST_CYC - 1)) begin
                    state   <= SETTLE_SMP == 0 ? ACCUM : SETTLE;
                    dig_rst <= 1'b0;
                    rst_cnt <= '0;
                    set_cnt <= '0;
                    wd      <= '0;
                    smp     <= '0;
                    acc     <= '0;
                end else begin
                    rst_cnt <= rst_cnt + RC_W'(1);
                end
                SETTLE: begin
                    wd <= cyc_done ? '0 : wd + WD_W'(1);
                    if (wd_exp) begin
                        state       <= IDLE;
                        dig_rst     <= 1'b1;
                        err_timeout <= 1'b1;
                        set_cnt     <= '0;
                        wd          <= '0;
                    end else if (cyc_done) begin
                        set_cnt <= set_cnt + SC_W'(1);
                        if (set_cnt == SC_W'(SETTLE_SMP - 1)) begin
                            state   <= ACCUM;
                            set_cnt <= '0;
                        end
                    end
                end
                ACCUM: begin
                    wd <= cyc_done ? '0 : wd + WD_W'(1);
                    if (wd_exp) begin
                        state       <= IDLE;
                        dig_rst     <= 1'b1;
                        err_timeout <= 1'b1;
                        smp         <= '0;
                        acc         <= '0;
                        wd          <= '0;
                    end else if (cyc_done) begin
                        // acc stays below osr_l here, so the final add cannot wrap
                        if (smp_last) begin
                            result       <= acc + OSR_W'(cmp);
                            result_valid <= 1'b1;
                            smp          <= '0;
                            acc          <= '0;
                            state        <= HOLD;
                        end else begin
                            smp <= smp + OSR_W'(1);
                            acc <= acc + OSR_W'(cmp);
                        end
                    end
                end
                HOLD: begin
                    if (cyc_done && cont_l)
                        overrun <= 1'b1;
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        state        <= cont_l ? ACCUM : IDLE;
                        dig_rst      <= !cont_l;
                        wd           <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
